// File: rtl/param_compress_unit.sv
// Two-stage block compressor: S1 classifies each 32-bit word into a tag/byte count,
// S2 packs the surviving bytes LSB-first and reports the packed length.
module param_compress_unit #(
    parameter int NUM_WORDS = 8,
    parameter int LEN_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wrtEn,
    input  logic                   mode,
    input  logic                   validIn,
    output logic                   readyIn,
    input  logic [32*NUM_WORDS-1:0] dataIn,
    output logic [32*NUM_WORDS-1:0] dataOut,
    output logic [2*NUM_WORDS-1:0]  tagOut,
    output logic [LEN_W-1:0]        lenOut,
    output logic                   validOut,
    input  logic                   readyOut
);

    localparam int DW    = 32 * NUM_WORDS;
    localparam int TW    = 2 * NUM_WORDS;
    localparam int CW    = 3 * NUM_WORDS;
    localparam int OFF_W = $clog2(4 * NUM_WORDS + 1);

    generate
        if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_words
            $error("param_compress_unit: NUM_WORDS must be in 1..16");
        end
        if (LEN_W < OFF_W) begin : g_bad_len
            $error("param_compress_unit: LEN_W too narrow for 4*NUM_WORDS bytes");
        end
    endgenerate

    logic            s1_valid_q, s1_valid_d;
    logic [TW-1:0]   s1_tag_q, s1_tag_d;
    logic [CW-1:0]   s1_cnt_q, s1_cnt_d;
    logic [DW-1:0]   s1_word_q;

    logic            s2_valid_q, s2_valid_d;
    logic [DW-1:0]   s2_data_q, s2_data_d;
    logic [TW-1:0]   s2_tag_q;
    logic [LEN_W-1:0] s2_len_q, s2_len_d;

    logic consume, s2_free, s1_adv, accept;

    assign consume = s2_valid_q & readyOut & wrtEn;
    assign s2_free = ~s2_valid_q | consume;
    assign s1_adv  = s1_valid_q & s2_free & wrtEn;
    // Gating with reset keeps readyIn low for the whole time reset is held.
    assign readyIn = reset & wrtEn & (~s1_valid_q | s1_adv);
    assign accept  = validIn & readyIn;

    assign s1_valid_d = accept | (s1_valid_q & ~s1_adv);
    assign s2_valid_d = s1_adv | (s2_valid_q & ~consume);

    // Bypass is folded into the tags here (all 11 / 4 bytes), so the mode
    // bit travels with the block without needing its own pipeline register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_classify
            logic [31:0] word;
            logic [1:0]  tag_w;
            logic [2:0]  cnt_w;

            assign word = dataIn[32*gi +: 32];

            always_comb begin
                tag_w = 2'b11;
                cnt_w = 3'd4;
                if (!mode) begin
                    if (word == 32'd0) begin
                        tag_w = 2'b00;
                        cnt_w = 3'd0;
                    end else if (word[31:8] == 24'd0) begin
                        tag_w = 2'b01;
                        cnt_w = 3'd1;
                    end else if (word[31:16] == 16'd0) begin
                        tag_w = 2'b10;
                        cnt_w = 3'd2;
                    end
                end
            end

            assign s1_tag_d[2*gi +: 2] = tag_w;
            assign s1_cnt_d[3*gi +: 3] = cnt_w;
        end
    endgenerate

    // Upper bytes of a short word are zero by classification, so shifting the
    // whole word into place needs no masking and leaves bytes >= lenOut zero.
    always_comb begin
        logic [OFF_W-1:0] acc;
        acc       = '0;
        s2_data_d = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            s2_data_d = s2_data_d | (DW'(s1_word_q[32*i +: 32]) << {acc, 3'b000});
            acc       = acc + OFF_W'(s1_cnt_q[3*i +: 3]);
        end
        s2_len_d = LEN_W'(acc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_cnt_q   <= '0;
            s1_word_q  <= '0;
        end else if (wrtEn) begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_tag_q  <= s1_tag_d;
                s1_cnt_q  <= s1_cnt_d;
                s1_word_q <= dataIn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
            s2_len_q   <= '0;
        end else if (wrtEn) begin
            s2_valid_q <= s2_valid_d;
            if (s1_adv) begin
                s2_data_q <= s2_data_d;
                s2_tag_q  <= s1_tag_q;
                s2_len_q  <= s2_len_d;
            end
        end
    end

    assign validOut = s2_valid_q;
    assign dataOut  = s2_data_q;
    assign tagOut   = s2_tag_q;
    assign lenOut   = s2_len_q;

endmodule

// File: tb/tb_param_compress_unit.sv
// Directed bench for param_compress_unit: expectations queued on acceptance,
// popped and compared when the output block is consumed.
module tb_param_compress_unit;

    localparam int NW = 8;
    localparam int LW = 8;

    logic           clk;
    logic           reset;
    logic           wrtEn;
    logic           mode;
    logic           validIn;
    logic           readyIn;
    logic [255:0]   dataIn;
    logic [255:0]   dataOut;
    logic [15:0]    tagOut;
    logic [7:0]     lenOut;
    logic           validOut;
    logic           readyOut;

    typedef struct packed {
        logic [255:0] d;
        logic [15:0]  t;
        logic [7:0]   l;
    } exp_t;

    exp_t sb[$];
    int   n_total     = 0;
    int   n_pass      = 0;
    int   n_delivered = 0;

    param_compress_unit #(.NUM_WORDS(NW), .LEN_W(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .wrtEn    (wrtEn),
        .mode     (mode),
        .validIn  (validIn),
        .readyIn  (readyIn),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .tagOut   (tagOut),
        .lenOut   (lenOut),
        .validOut (validOut),
        .readyOut (readyOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Byte-by-byte reference packer.
    function automatic exp_t model(input logic [255:0] din, input bit m);
        exp_t        e;
        int          pos;
        logic [31:0] w;
        logic [1:0]  tg;
        int          n;
        e   = '0;
        pos = 0;
        for (int k = 0; k < NW; k++) begin
            w = din[32*k +: 32];
            if (m)                    begin tg = 2'b11; n = 4; end
            else if (w == 0)          begin tg = 2'b00; n = 0; end
            else if (w < 32'h100)     begin tg = 2'b01; n = 1; end
            else if (w < 32'h10000)   begin tg = 2'b10; n = 2; end
            else                      begin tg = 2'b11; n = 4; end
            e.t[2*k +: 2] = tg;
            for (int b = 0; b < n; b++) begin
                e.d[8*pos +: 8] = w[8*b +: 8];
                pos++;
            end
        end
        e.l = 8'(pos);
        return e;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 255));
            2:       return 32'($urandom_range(256, 65535));
            default: return $urandom;
        endcase
    endfunction

    // Output monitor: scoreboard compare on consume, stability while stalled.
    logic         hold_q = 1'b0;
    logic [255:0] prev_d;
    logic [15:0]  prev_t;
    logic [7:0]   prev_l;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (hold_q) begin
                chk("hold_valid", 256'(validOut), 256'(1));
                chk("hold_data", dataOut, prev_d);
                chk("hold_tag", 256'(tagOut), 256'(prev_t));
                chk("hold_len", 256'(lenOut), 256'(prev_l));
            end
            if (validOut && readyOut && wrtEn) begin
                chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
                if (sb.size() != 0) begin
                    chk("out_data", dataOut, sb[0].d);
                    chk("out_tag", 256'(tagOut), 256'(sb[0].t));
                    chk("out_len", 256'(lenOut), 256'(sb[0].l));
                    void'(sb.pop_front());
                    n_delivered <= n_delivered + 1;
                end
            end
            hold_q <= validOut && !(readyOut && wrtEn);
            prev_d <= dataOut;
            prev_t <= tagOut;
            prev_l <= lenOut;
        end else begin
            hold_q <= 1'b0;
        end
    end

    // Single block with latency check; entered and left at posedge+1.
    task automatic single(input logic [255:0] din, input bit m, input exp_t e, input string nm);
        validIn = 1'b1;
        dataIn  = din;
        mode    = m;
        @(negedge clk);
        chk({nm, "_readyIn"}, 256'(readyIn), 256'(1));
        if (readyIn) sb.push_back(e);
        @(posedge clk); #1;
        validIn = 1'b0;
        dataIn  = '0;
        @(negedge clk);
        chk({nm, "_lat1"}, 256'(validOut), 256'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_lat2"}, 256'(validOut), 256'(1));
        @(posedge clk); #1;
    endtask

    // Stream n blocks back-to-back; rnd=0 stalls readyOut in cycles 3..6.
    task automatic stream(input int n, input bit rnd);
        logic [255:0] blk [16];
        bit           md  [16];
        int           idx;
        int           c;
        int           base;
        bit           saw_stall;
        idx       = 0;
        c         = 0;
        base      = n_delivered;
        saw_stall = 0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < NW; k++) blk[i][32*k +: 32] = rnd_word();
            md[i] = rnd ? 1'($urandom_range(0, 1)) : (i == 2);
        end
        while ((idx < n || sb.size() != 0) && c < 300) begin
            readyOut = rnd ? 1'($urandom_range(0, 1)) : !(c >= 3 && c <= 6);
            validIn  = (idx < n);
            if (idx < n) begin
                dataIn = blk[idx];
                mode   = md[idx];
            end
            @(negedge clk);
            if (validIn && !readyIn) saw_stall = 1;
            if (validIn && readyIn) begin
                sb.push_back(model(dataIn, mode));
                idx++;
            end
            @(posedge clk); #1;
            c++;
        end
        validIn  = 1'b0;
        readyOut = 1'b1;
        chk("stream_no_timeout", 256'(c < 300), 256'(1));
        chk("stream_accepted", 256'(idx), 256'(n));
        chk("stream_delivered", 256'(n_delivered - base), 256'(n));
        if (!rnd) chk("stream_readyIn_dropped", 256'(saw_stall), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d_all;
        logic [255:0] d_sp;
        exp_t         e;

        reset    = 1'b0;
        wrtEn    = 1'b1;
        mode     = 1'b0;
        validIn  = 1'b0;
        readyOut = 1'b1;
        dataIn   = '0;

        #3;
        chk("rst_validOut", 256'(validOut), 256'(0));
        chk("rst_readyIn", 256'(readyIn), 256'(0));
        chk("rst_dataOut", dataOut, 256'(0));
        chk("rst_tagOut", 256'(tagOut), 256'(0));
        chk("rst_lenOut", 256'(lenOut), 256'(0));
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 256'(readyIn), 256'(1));
        @(posedge clk); #1;

        d_all = {8{32'hFEDCBA98}};
        e = '{d: d_all, t: 16'hFFFF, l: 8'd32};
        single(d_all, 1'b0, e, "full_words");

        e = '{d: 256'd0, t: 16'h0000, l: 8'd0};
        single(256'd0, 1'b0, e, "zero_words");

        d_sp = {32'h0, 32'h0, 32'h0, 32'h0, 32'h8765, 32'h43, 32'h0, 32'h21};
        e = '{d: 256'h87654321, t: 16'h0091, l: 8'd4};
        single(d_sp, 1'b0, e, "mixed_compress");

        e = '{d: d_sp, t: 16'hFFFF, l: 8'd32};
        single(d_sp, 1'b1, e, "mixed_bypass");

        // Freeze: block parked in S2, wrtEn low must hold everything.
        readyOut = 1'b0;
        validIn  = 1'b1;
        dataIn   = d_sp;
        mode     = 1'b0;
        @(negedge clk);
        if (readyIn) sb.push_back(model(d_sp, 1'b0));
        @(posedge clk); #1;
        validIn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wrtEn    = 1'b0;
        validIn  = 1'b1;
        dataIn   = {8{32'h00001234}};
        readyOut = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("freeze_readyIn", 256'(readyIn), 256'(0));
            chk("freeze_validOut", 256'(validOut), 256'(1));
            @(posedge clk); #1;
        end
        wrtEn   = 1'b1;
        validIn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("freeze_drained", 256'(validOut), 256'(0));
        @(posedge clk); #1;

        stream(5, 1'b0);
        stream(16, 1'b1);

        // Mid-stream reset with two blocks in flight.
        readyOut = 1'b1;
        validIn  = 1'b1;
        mode     = 1'b0;
        dataIn   = {8{32'h000000AA}};
        @(posedge clk); #1;
        dataIn   = {8{32'h0000BBBB}};
        @(posedge clk); #1;
        validIn  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_validOut", 256'(validOut), 256'(0));
        chk("midrst_readyIn", 256'(readyIn), 256'(0));
        chk("midrst_dataOut", dataOut, 256'(0));
        chk("midrst_tagOut", 256'(tagOut), 256'(0));
        chk("midrst_lenOut", 256'(lenOut), 256'(0));
        @(negedge clk);
        chk("midrst_readyIn_held", 256'(readyIn), 256'(0));
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready_release", 256'(readyIn), 256'(1));
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_stale", 256'(validOut), 256'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/param_compress_unit.md
PARAM_COMPRESS_UNIT -- requirements
Module: param_compress_unit

Interface
REQ-001 The block SHALL take parameter NUM_WORDS, default 8, which is the number of 32-bit words per block (legal range 1..16).
REQ-002 The block SHALL take parameter LEN_W, default 8, which is the width of lenOut; it must be at least clog2(4*NUM_WORDS+1), otherwise elaboration fails.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk, in, 1, the single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- wrtEn, in, 1, pipeline enable; low freezes all state.
- mode, in, 1, compression mode: 0 = compress, 1 = raw bypass; sampled with validIn.
- validIn, in, 1, an input block is present.
- readyIn, out, 1, the block can accept an input this cycle.
- dataIn, in, 32*NUM_WORDS, input words; word i is bits [32i+31:32i].
- dataOut, out, 32*NUM_WORDS, packed compressed bytes, LSB-aligned.
- tagOut, out, 2*NUM_WORDS, per-word tag; tag i is bits [2i+1:2i].
- lenOut, out, LEN_W, number of valid bytes in dataOut.
- validOut, out, 1, output block is valid.
- readyOut, in, 1, downstream accepts the output block.

Function
REQ-004 An input SHALL be accepted when validIn, readyIn and wrtEn are all high in the same cycle.
REQ-005 An output SHALL be consumed when validOut, readyOut and wrtEn are all high in the same cycle.
REQ-006 In compress mode, each word SHALL get a tag and a byte count:
- tag 00: word == 0, 0 bytes.
- tag 01: bits [31:8] == 0 and word != 0, 1 byte.
- tag 10: bits [31:16] == 0 and bits [15:8] != 0, 2 bytes.
- tag 11: otherwise, 4 bytes.
REQ-007 In bypass mode, every tag SHALL be 11, and dataOut SHALL equal dataIn.
REQ-008 The compressed bytes of word i SHALL be placed LSB-first at byte offset sum(bytes of words 0..i-1); bytes of dataOut at or above lenOut SHALL be 0.
REQ-009 lenOut SHALL equal the sum of the byte counts of all words, zero-extended to LEN_W.
REQ-010 The block SHALL be a 2-stage pipeline:
- S1 registers the tags, byte counts and raw words.
- S2 registers the packed dataOut, tagOut and lenOut.
- Latency from acceptance to validOut is 2 cycles.
REQ-011 With readyOut held high, the block SHALL sustain one block per cycle throughput.
REQ-012 Backpressure SHALL work as follows:
- Each stage advances only when the stage downstream of it is empty or being consumed.
- readyIn = wrtEn AND (S1 empty OR S1 advancing).
- readyIn is combinational and does not depend on validIn.
REQ-013 While validOut is high and readyOut is low, dataOut, tagOut, lenOut and validOut SHALL remain stable.
REQ-014 When wrtEn is low, no stage SHALL change state, readyIn SHALL be 0, and outputs SHALL hold.
REQ-015 Simultaneous accept and consume in the same cycle SHALL pass data through without a bubble or loss.
REQ-016 The mode bit SHALL travel with its block, so a mode change between consecutive blocks affects only the later block.

Reset
REQ-017 When reset is low, the following outputs SHALL be driven to these values:
- validOut = 0.
- dataOut = 0.
- tagOut = 0.
- lenOut = 0.
- readyIn = 0.
REQ-018 When reset is low, both stage valid flags SHALL clear immediately, independent of clk.
REQ-019 A reset asserted mid-stream SHALL discard all in-flight blocks; none may appear on the output after reset is released.
REQ-020 readyIn SHALL return to 1 in the first cycle after reset is released, provided wrtEn is high.

Verification
REQ-021 Apply all words = 0xFEDCBA98 in mode 0 -> after 2 cycles: validOut = 1, tagOut = 16'hFFFF, lenOut = 32, dataOut = dataIn.
REQ-022 Apply all words = 0 -> tagOut = 16'h0000, lenOut = 0, dataOut = 0.
REQ-023 Apply w0 = 0x21, w1 = 0, w2 = 0x43, w3 = 0x8765, w4..w7 = 0 -> tagOut = 16'h0091, lenOut = 4, dataOut = 256'h87654321.
REQ-024 Apply the REQ-023 data in mode 1 -> tagOut = 16'hFFFF, lenOut = 32, dataOut = dataIn.
REQ-025 Stream 5 blocks back-to-back and hold readyOut low for cycles 3 to 6 -> the output stays stable while stalled, readyIn drops when both stages are full, and all 5 blocks are delivered in order with none lost or duplicated.
REQ-026 Pulse reset low with 2 blocks in flight -> validOut = 0 immediately, no stale output after release, and readyIn = 1 on the next cycle.
